// File: rtl/wm_phase_actuator.sv
// Washing-machine phase actuator: takes one-hot soak/wash/rinse/spin level
// requests and drives the fill valve, drum motor and drain valve through timed
// fill, run and drain states, reporting completion or abort to the controller.
module wm_phase_actuator #(
  parameter int PRESCALE    = 4,
  parameter int CNT_W       = 8,
  parameter int FILL_TICKS  = 3,
  parameter int DRAIN_TICKS = 2,
  parameter int SOAK_TICKS  = 5,
  parameter int WASH_TICKS  = 6,
  parameter int RINSE_TICKS = 4,
  parameter int SPIN_TICKS  = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       lid,
  input  logic       soak_Operation,
  input  logic       wash_Operation,
  input  logic       rinse_Operation,
  input  logic       spin_Operation,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       motor_on,
  output logic [1:0] motor_speed,
  output logic       water_full,
  output logic       busy,
  output logic       phase_done,
  output logic       aborted,
  output logic       req_error
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE, HOLD} state_e;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0] PH_SOAK  = 2'd0;
  localparam logic [1:0] PH_WASH  = 2'd1;
  localparam logic [1:0] PH_RINSE = 2'd2;
  localparam logic [1:0] PH_SPIN  = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             preSpin_q, preSpin_d;
  logic             abort_q, abort_d;
  logic             waterFull_q, waterFull_d;
  logic             aborted_q, aborted_d;
  logic             reqError_q, reqError_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] tick_q, tick_d;

  logic [3:0]       reqVec;
  logic [1:0]       reqId;
  logic             reqLatched, oneHot, multiReq, paused, tickNow, expire, dropNow;
  logic [CNT_W-1:0] runTicks, target;

  assign reqVec     = {spin_Operation, rinse_Operation, wash_Operation, soak_Operation};
  assign reqId      = soak_Operation ? PH_SOAK : wash_Operation ? PH_WASH :
                      rinse_Operation ? PH_RINSE : PH_SPIN;
  assign reqLatched = reqVec[phase_q];
  assign oneHot     = (reqVec != 4'd0) && ((reqVec & (reqVec - 4'd1)) == 4'd0);
  assign multiReq   = (reqVec != 4'd0) && !oneHot;
  assign paused     = lid && ((state_q == FILL) || (state_q == RUN));
  assign tickNow    = (presc_q == PW'(PRESCALE - 1));
  assign expire     = tickNow && !paused && (tick_q == target - CNT_W'(1));
  assign dropNow    = (state_q == DRAIN) && preSpin_q && !abort_q && !reqLatched;

  // Select the run length of the latched phase and the duration of the current state.
  always_comb begin
    runTicks = CNT_W'(SOAK_TICKS);
    target   = CNT_W'(1);
    case (phase_q)
      PH_WASH:  runTicks = CNT_W'(WASH_TICKS);
      PH_RINSE: runTicks = CNT_W'(RINSE_TICKS);
      PH_SPIN:  runTicks = CNT_W'(SPIN_TICKS);
      default:  runTicks = CNT_W'(SOAK_TICKS);
    endcase
    case (state_q)
      FILL:    target = CNT_W'(FILL_TICKS);
      RUN:     target = runTicks;
      DRAIN:   target = CNT_W'(DRAIN_TICKS);
      default: target = CNT_W'(1);
    endcase
  end

  // Phase sequencing, cancel handling and timing; timers restart on each state change.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    preSpin_d   = preSpin_q;
    abort_d     = abort_q;
    waterFull_d = waterFull_q;
    aborted_d   = 1'b0;
    reqError_d  = 1'b0;
    presc_d     = presc_q;
    tick_d      = tick_q;

    if (!paused) begin
      presc_d = tickNow ? '0 : presc_q + PW'(1);
      if (tickNow && (tick_q != '1)) begin
        tick_d = tick_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (!lid && oneHot) begin
          phase_d   = reqId;
          abort_d   = 1'b0;
          preSpin_d = 1'b0;
          if (reqId == PH_SPIN) begin
            preSpin_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            state_d = waterFull_q ? RUN : FILL;
          end
        end else if (!lid && multiReq) begin
          reqError_d = 1'b1;
        end
      end
      FILL: begin
        if (!reqLatched) begin
          aborted_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = DRAIN;
        end else if (expire) begin
          waterFull_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (!reqLatched) begin
          aborted_d = 1'b1;
          if (waterFull_q) begin
            abort_d = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end else if (expire) begin
          state_d = (phase_q == PH_RINSE) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (dropNow) begin
          aborted_d = 1'b1;
          abort_d   = 1'b1;
        end
        if (expire) begin
          waterFull_d = 1'b0;
          preSpin_d   = 1'b0;
          if (abort_q || dropNow) begin
            state_d = IDLE;
          end else if (preSpin_q) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = HOLD;
      HOLD: begin
        if (!reqLatched) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      presc_d = '0;
      tick_d  = '0;
    end
  end

  // State, flags, timers and registered pulses; reset drops everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= PH_SOAK;
      preSpin_q   <= 1'b0;
      abort_q     <= 1'b0;
      waterFull_q <= 1'b0;
      aborted_q   <= 1'b0;
      reqError_q  <= 1'b0;
      presc_q     <= '0;
      tick_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      preSpin_q   <= preSpin_d;
      abort_q     <= abort_d;
      waterFull_q <= waterFull_d;
      aborted_q   <= aborted_d;
      reqError_q  <= reqError_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
    end
  end

  // Actuators decoded from state; an open lid cuts the fill valve and motor at once.
  always_comb begin
    fill_valve  = (state_q == FILL) && !lid;
    drain_valve = (state_q == DRAIN);
    motor_on    = (state_q == RUN) && !lid && (phase_q != PH_SOAK);
    motor_speed = 2'd0;
    if (motor_on) begin
      motor_speed = (phase_q == PH_SPIN) ? 2'd3 : 2'd1;
    end
    water_full  = waterFull_q;
    busy        = (state_q != IDLE);
    phase_done  = (state_q == DONE);
    aborted     = aborted_q;
    req_error   = reqError_q;
  end

endmodule

// File: tb/tb_wm_phase_actuator.sv
// Testbench for wm_phase_actuator: directed and random phases, cancels, lid
// pauses, request errors and resets, checked through an event scoreboard.
module tb_wm_phase_actuator;

  localparam int P        = 4;
  localparam int FILL_T   = 3;
  localparam int DRAIN_T  = 2;
  localparam int SOAK_T   = 5;
  localparam int WASH_T   = 6;
  localparam int RINSE_T  = 4;
  localparam int SPIN_T   = 5;

  typedef struct {
    int kind;
    int fill;
    int drain;
    int sp1;
    int sp3;
    int motor;
    int busyC;
    int done;
    int abrt;
    int water;
  } evT;

  logic       clock;
  logic       reset_n;
  logic       lid;
  logic [3:0] req;
  logic       fill_valve, drain_valve, motor_on, water_full, busy;
  logic       phase_done, aborted, req_error;
  logic [1:0] motor_speed;

  int  vectors = 0;
  int  miscompares = 0;
  evT  expQ[$];
  int  modelWf = 0;

  int  accFill = 0, accDrain = 0, accSp1 = 0, accSp3 = 0, accMotor = 0;
  int  accBusy = 0, accDone = 0, accAbort = 0;
  bit  prevBusy = 1'b0;

  wm_phase_actuator #(
    .PRESCALE(P), .CNT_W(8), .FILL_TICKS(FILL_T), .DRAIN_TICKS(DRAIN_T),
    .SOAK_TICKS(SOAK_T), .WASH_TICKS(WASH_T), .RINSE_TICKS(RINSE_T), .SPIN_TICKS(SPIN_T)
  ) dut (
    .clock(clock), .reset_n(reset_n), .lid(lid),
    .soak_Operation(req[0]), .wash_Operation(req[1]),
    .rinse_Operation(req[2]), .spin_Operation(req[3]),
    .fill_valve(fill_valve), .drain_valve(drain_valve), .motor_on(motor_on),
    .motor_speed(motor_speed), .water_full(water_full), .busy(busy),
    .phase_done(phase_done), .aborted(aborted), .req_error(req_error)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic evT mkEv(int kind, int fill, int drain, int sp1, int sp3, int motor,
                              int busyC, int done, int abrt, int water);
    evT e;
    e.kind = kind; e.fill = fill; e.drain = drain; e.sp1 = sp1; e.sp3 = sp3;
    e.motor = motor; e.busyC = busyC; e.done = done; e.abrt = abrt; e.water = water;
    return e;
  endfunction

  function automatic int runCycles(int ph);
    case (ph)
      0: return SOAK_T * P;
      1: return WASH_T * P;
      2: return RINSE_T * P;
      default: return SPIN_T * P;
    endcase
  endfunction

  // Reference model: a completed phase, from the phase rules and durations.
  function automatic evT modelPhase(int ph, int wf, int lidL);
    int fill = (ph != 3 && wf == 0) ? FILL_T * P : 0;
    int pre  = (ph == 3) ? DRAIN_T * P : 0;
    int post = (ph == 2) ? DRAIN_T * P : 0;
    int run  = runCycles(ph);
    int sp1  = (ph == 1 || ph == 2) ? run : 0;
    int sp3  = (ph == 3) ? run : 0;
    int wEnd = (ph <= 1) ? 1 : 0;
    return mkEv(0, fill, pre + post, sp1, sp3, sp1 + sp3,
                fill + pre + run + lidL + post + 2, 1, 0, wEnd);
  endfunction

  // Reference model: request dropped after k cycles of fill (0), motor (1) or pre-spin drain (2).
  function automatic evT modelCancel(int ph, int stage, int k, int wf);
    int dr = DRAIN_T * P;
    int fill;
    if (stage == 0) return mkEv(0, k + 1, dr, 0, 0, 0, k + 1 + dr, 0, 1, 0);
    if (stage == 2) return mkEv(0, 0, dr, 0, 0, 0, dr, 0, 1, 0);
    if (ph == 3)    return mkEv(0, 0, dr, 0, k + 1, k + 1, dr + k + 1, 0, 1, 0);
    fill = (wf == 0) ? FILL_T * P : 0;
    return mkEv(0, fill, dr, k + 1, 0, k + 1, fill + k + 1 + dr, 0, 1, 0);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic printSummary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  task automatic timeoutAbort(input string what);
    vectors++;
    miscompares++;
    $display("[TB] FAIL timeout waiting for %s: got no event, expected one within bound", what);
    printSummary();
    $finish;
  endtask

  task automatic compareEv(input evT a);
    evT e;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected event: got kind %0d, expected none pending", a.kind);
    end else begin
      e = expQ.pop_front();
      checkOutput("event kind", a.kind, e.kind);
      checkOutput("fill cycles", a.fill, e.fill);
      checkOutput("drain cycles", a.drain, e.drain);
      checkOutput("speed1 cycles", a.sp1, e.sp1);
      checkOutput("speed3 cycles", a.sp3, e.sp3);
      checkOutput("motor cycles", a.motor, e.motor);
      checkOutput("busy cycles", a.busyC, e.busyC);
      checkOutput("phase_done pulses", a.done, e.done);
      checkOutput("aborted pulses", a.abrt, e.abrt);
      checkOutput("water_full at end", a.water, e.water);
    end
  endtask

  // Monitor: accumulates actuator activity while busy and reports each finished
  // transaction (busy falling) or request error to the scoreboard.
  always @(negedge clock) begin
    if (phase_done) accDone++;
    if (aborted) accAbort++;
    if (busy) begin
      accBusy++;
      if (fill_valve) accFill++;
      if (drain_valve) accDrain++;
      if (motor_on) accMotor++;
      if (motor_speed == 2'd1) accSp1++;
      if (motor_speed == 2'd3) accSp3++;
    end
    if (req_error) compareEv(mkEv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (prevBusy && !busy) begin
      compareEv(mkEv(0, accFill, accDrain, accSp1, accSp3, accMotor, accBusy,
                     accDone, accAbort, int'(water_full)));
      accFill = 0; accDrain = 0; accSp1 = 0; accSp3 = 0; accMotor = 0;
      accBusy = 0; accDone = 0; accAbort = 0;
    end
    prevBusy = busy;
  end

  task automatic applyStimulus(input logic [3:0] r, input logic l);
    @(posedge clock);
    #2;
    req = r;
    lid = l;
  endtask

  // Wait for k sampled cycles of: 0 fill, 1 drain, 2 motor, 3 phase_done, other busy low.
  task automatic waitCount(input int sel, input int k);
    int n = 0;
    int guard = 0;
    while (n < k) begin
      @(negedge clock);
      guard++;
      case (sel)
        0: if (fill_valve) n++;
        1: if (drain_valve) n++;
        2: if (motor_on) n++;
        3: if (phase_done) n++;
        default: if (!busy) n++;
      endcase
      if (guard > 400) timeoutAbort($sformatf("condition %0d", sel));
    end
  endtask

  task automatic runPhase(input int ph, input int startLid, input int lidK, input int lidL);
    logic [3:0] r = 4'(1 << ph);
    expQ.push_back(modelPhase(ph, modelWf, lidL));
    if (startLid > 0) begin
      applyStimulus(r, 1'b1);
      repeat (startLid - 1) @(posedge clock);
    end
    applyStimulus(r, 1'b0);
    if (lidL > 0) begin
      waitCount(2, lidK);
      applyStimulus(r, 1'b1);
      repeat (lidL - 1) @(posedge clock);
      applyStimulus(r, 1'b0);
    end
    waitCount(3, 1);
    applyStimulus(4'd0, 1'b0);
    waitCount(4, 1);
    modelWf = (ph <= 1) ? 1 : 0;
  endtask

  task automatic runCancel(input int ph, input int stage, input int k);
    expQ.push_back(modelCancel(ph, stage, k, modelWf));
    applyStimulus(4'(1 << ph), 1'b0);
    waitCount((stage == 0) ? 0 : (stage == 1) ? 2 : 1, k);
    applyStimulus(4'd0, 1'b0);
    waitCount(4, 1);
    modelWf = 0;
  endtask

  task automatic runReqError(input logic [3:0] m);
    expQ.push_back(mkEv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(m, 1'b1);
    applyStimulus(m, 1'b1);
    applyStimulus(m, 1'b0);
    applyStimulus(4'd0, 1'b0);
    repeat (3) @(posedge clock);
  endtask

  task automatic runResetMidFill(input int k);
    expQ.push_back(mkEv(0, k, 0, 0, 0, 0, k, 0, 0, 0));
    applyStimulus(4'b0010, 1'b0);
    waitCount(0, k);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset fill_valve", int'(fill_valve), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset motor_speed", int'(motor_speed), 0);
    checkOutput("reset drain_valve", int'(drain_valve), 0);
    applyStimulus(4'd0, 1'b0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("post-reset busy", int'(busy), 0);
    checkOutput("post-reset water_full", int'(water_full), 0);
    modelWf = 0;
  endtask

  // Directed scenarios first, then a randomized mix.
  initial begin
    int sel, ph, stage, k, m;
    reset_n = 1'b0;
    lid = 1'b0;
    req = 4'd0;
    #1;
    checkOutput("init fill_valve", int'(fill_valve), 0);
    checkOutput("init motor_on", int'(motor_on), 0);
    checkOutput("init busy", int'(busy), 0);
    checkOutput("init water_full", int'(water_full), 0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("idle phase_done", int'(phase_done), 0);

    runPhase(1, 0, 0, 0);
    runPhase(2, 0, 0, 0);
    runPhase(3, 0, 0, 0);
    runPhase(1, 0, 8, 10);
    runCancel(1, 1, 4);
    runReqError(4'b1010);
    runResetMidFill(5);
    runCancel(3, 2, DRAIN_T * P - 1);
    runCancel(1, 1, WASH_T * P - 1);
    runPhase(0, 3, 0, 0);
    runCancel(3, 1, SPIN_T * P - 1);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 4);
      ph  = $urandom_range(0, 3);
      if (sel == 1) begin
        ph = $urandom_range(1, 3);
        if (ph == 3) stage = $urandom_range(1, 2);
        else stage = (modelWf == 0 && $urandom_range(0, 1) == 1) ? 0 : 1;
        if (stage == 0) k = $urandom_range(1, FILL_T * P - 1);
        else if (stage == 2) k = $urandom_range(1, DRAIN_T * P - 1);
        else k = $urandom_range(1, runCycles(ph) - 1);
        runCancel(ph, stage, k);
      end else if (sel == 2) begin
        m = $urandom_range(3, 15);
        if ($countones(m) < 2) m = m | 3;
        runReqError(4'(m));
      end else if (sel == 3 && modelWf == 0) begin
        runResetMidFill($urandom_range(1, FILL_T * P - 1));
      end else if (ph != 0 && $urandom_range(0, 1) == 1) begin
        runPhase(ph, 0, $urandom_range(1, runCycles(ph) - 1), $urandom_range(1, 12));
      end else begin
        runPhase(ph, (sel == 4) ? $urandom_range(1, 4) : 0, 0, 0);
      end
    end

    repeat (5) @(posedge clock);
    checkOutput("pending expectations", expQ.size(), 0);
    printSummary();
    $finish;
  end

endmodule

// File: doc/wm_phase_actuator.md
Name: wm_phase_actuator

Overview:
- Responder end of the washing-machine controller's phase command interface.
- Accepts one-hot level requests for soak, wash, rinse and spin.
- Sequences the fill valve, drum motor and drain valve for timed durations, and reports completion or abort back to the controller.
- Sits between the controller FSM and the physical valve and motor drivers.

Parameters:
PRESCALE, 4, clock cycles per timing tick (>=1)
CNT_W, 8, width of the tick counter
FILL_TICKS, 3, ticks to fill the drum
DRAIN_TICKS, 2, ticks to drain the drum
SOAK_TICKS, 5, soak run length in ticks
WASH_TICKS, 6, wash run length in ticks
RINSE_TICKS, 4, rinse run length in ticks
SPIN_TICKS, 5, spin run length in ticks

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
lid  in  1  1 = lid open
soak_Operation  in  1  soak request (level)
wash_Operation  in  1  wash request (level)
rinse_Operation  in  1  rinse request (level)
spin_Operation  in  1  spin request (level)
fill_valve  out  1  water inlet valve on
drain_valve  out  1  drain valve on
motor_on  out  1  drum motor enabled
motor_speed  out  2  0 = stop, 1 = agitate, 3 = spin
water_full  out  1  drum holds water
busy  out  1  phase in progress (not IDLE)
phase_done  out  1  one-cycle pulse: requested phase completed
aborted  out  1  one-cycle pulse: phase abandoned
req_error  out  1  one-cycle pulse: more than one request high in IDLE

Behaviour:
- Single clock domain; reset is asynchronous and active-low.
- Reset: all outputs 0, water_full 0, state IDLE, counters 0. Reset mid-phase drops all actuators immediately.
- States: IDLE, FILL, RUN, DRAIN, DONE, HOLD.
- Outputs are Moore-decoded from registered state. Pulses (phase_done, aborted, req_error) are registered.
- Timing:
  - Prescaler and tick counter clear on every state entry.
  - A state of N ticks lasts exactly N*PRESCALE cycles while not paused.
- IDLE:
  - Exactly one request high: latch phase id; busy=1 next cycle.
  - Soak, wash or rinse: go to FILL if water_full=0, else go to RUN.
  - Spin: go to DRAIN with pre_spin flag set.
  - Two or more requests high: req_error pulse, remain IDLE.
  - Requests are ignored while lid=1.
- FILL: fill_valve=1. On FILL_TICKS elapsed: water_full<=1, go to RUN.
- RUN:
  - motor_on=1 except for soak (motor_on=0, speed 0).
  - motor_speed: wash/rinse = 1, spin = 3.
  - On phase ticks elapsed: rinse goes to DRAIN; soak, wash and spin go to DONE.
- DRAIN:
  - drain_valve=1. On DRAIN_TICKS elapsed: water_full<=0.
  - pre_spin=1: clear pre_spin, go to RUN.
  - Otherwise: go to DONE, or to IDLE if the abort flag is set.
- DONE: phase_done=1 for one cycle, then go to HOLD.
- HOLD: wait until the latched request is low, then go to IDLE. No re-trigger without release.
- Lid open in FILL or RUN:
  - fill_valve, motor_on and motor_speed forced to 0 the same cycle (combinational gate).
  - Prescaler and counter freeze.
  - Resume from the frozen count when lid closes.
  - DRAIN continues with lid open.
- Latched request drops in FILL or RUN (cancel):
  - aborted pulse; actuators off next cycle.
  - Go to DRAIN if water_full=1 or in FILL, else to IDLE.
  - No phase_done.
- Latched request drops during pre-spin DRAIN: aborted pulse; the drain completes, then IDLE.
- Simultaneous tick expiry and request drop: abort wins.
- Counters saturate; no wrap is reachable with legal parameters (ticks < 2^CNT_W).

Test Plan:
- Wash from empty (defaults), wash_Operation held:
  - fill_valve high 12 cycles, then motor_speed=1 for 24 cycles.
  - phase_done pulses once; water_full stays 1; HOLD until release.
- Rinse with water_full=1:
  - RUN 16 cycles at speed 1, then drain_valve 8 cycles.
  - water_full->0, then phase_done.
- Spin:
  - drain 8 cycles, then motor_speed=3 for 20 cycles, then phase_done.
- Lid open for 10 cycles mid-wash:
  - motor off during the lid-open window.
  - Total RUN length 34 cycles; single phase_done.
- Wash request dropped at RUN cycle 5:
  - aborted pulse, drain 8 cycles, then IDLE, no phase_done.
- wash+spin high together in IDLE: req_error pulse, busy stays 0.
- Reset asserted mid-FILL: all outputs 0 asynchronously; after release, IDLE, water_full 0.
